gate_level_full_adder: RTL and testbench

- Single-bit full adder (a + b + c -> {h, l}) built strictly from 2-input NAND primitives, with one registered output stage.
- Leaf cell of the ripple-carry and multi-bit adder chains; the high bit h feeds the next stage's c.
- LANES parameter instantiates independent parallel adder slices that share one clock, one reset and one valid qualifier.

---
 rtl/gate_level_full_adder.sv | 84 ++++++++
 tb/tb_gate_level_full_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gate_level_full_adder.sv
// LANES-wide single-bit full adder built from 2-input NAND gates, one registered stage.
// Optional GATE_LEVEL_FULL_ADDER_CHECK_EN adds a behavioural reference and sticky err flag.
module gate_level_full_adder #(
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic [LANES-1:0] c,
    output logic             out_valid,
    output logic [LANES-1:0] h,
    output logic [LANES-1:0] l
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
    ,
    output logic             err
`endif
);

    wire [LANES-1:0] n1, n2, n3, x, n5, n6, n7, sum, carry;

    // Nine-NAND network per slice: x = a^b, sum = x^c, carry = NAND(n1, n5).
    for (genvar i = 0; i < LANES; i++) begin : g_slice
        nand g_n1 (n1[i],    a[i],  b[i]);
        nand g_n2 (n2[i],    a[i],  n1[i]);
        nand g_n3 (n3[i],    b[i],  n1[i]);
        nand g_x  (x[i],     n2[i], n3[i]);
        nand g_n5 (n5[i],    x[i],  c[i]);
        nand g_n6 (n6[i],    x[i],  n5[i]);
        nand g_n7 (n7[i],    c[i],  n5[i]);
        nand g_s  (sum[i],   n6[i], n7[i]);
        nand g_c  (carry[i], n1[i], n5[i]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            h         <= '0;
            l         <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                h <= carry;
                l <= sum;
            end
        end
    end

`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
    logic [LANES-1:0] ref_carry, ref_sum;
    logic [LANES-1:0] ref_h, ref_l;

    // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        logic [1:0] total;
        ref_carry = '0;
        ref_sum   = '0;
        for (int i = 0; i < LANES; i++) begin
            total        = 2'(a[i]) + 2'(b[i]) + 2'(c[i]);
            ref_carry[i] = total[1];
            ref_sum[i]   = total[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_h <= '0;
            ref_l <= '0;
            err   <= 1'b0;
        end else begin
            if (in_valid) begin
                ref_h <= ref_carry;
                ref_l <= ref_sum;
            end
            // Compares the registered pair, so err lags the offending result by one cycle.
            if (out_valid && ({h, l} != {ref_h, ref_l}))
                err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_level_full_adder.sv
// Directed-vector bench for gate_level_full_adder: LANES=1, LANES=4 and a two-slice ripple chain.
module tb_gate_level_full_adder;

    logic clk;
    logic rst_n;

    logic       v1, a1, b1, c1;
    logic       ov1, h1, l1;

    logic       v4;
    logic [3:0] a4, b4, c4;
    logic       ov4;
    logic [3:0] h4, l4;

    logic       v_lo, a_lo, b_lo, c_lo, ov_lo, h_lo, l_lo;
    logic       v_hi, a_hi, b_hi, ov_hi, h_hi, l_hi;

`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
    logic err1, err4, err_lo, err_hi;
`endif

    int n_vec = 0;
    int n_miss = 0;

    gate_level_full_adder #(.LANES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
        .out_valid(ov1), .h(h1), .l(l1)
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
        , .err(err1)
`endif
    );

    gate_level_full_adder #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c(c4),
        .out_valid(ov4), .h(h4), .l(l4)
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
        , .err(err4)
`endif
    );

    gate_level_full_adder #(.LANES(1)) u_lo (
        .clk(clk), .rst_n(rst_n), .in_valid(v_lo), .a(a_lo), .b(b_lo), .c(c_lo),
        .out_valid(ov_lo), .h(h_lo), .l(l_lo)
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
        , .err(err_lo)
`endif
    );

    gate_level_full_adder #(.LANES(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .in_valid(v_hi), .a(a_hi), .b(b_hi), .c(h_lo),
        .out_valid(ov_hi), .h(h_hi), .l(l_hi)
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
        , .err(err_hi)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge and land 1 ns after it, away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed truth table indexed by {a,b,c}, value {h,l}.
    logic [1:0] exp_tbl [8];

    initial begin
        exp_tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        rst_n = 1'b0;
        {v1, a1, b1, c1} = '0;
        {v4, a4, b4, c4} = '0;
        {v_lo, a_lo, b_lo, c_lo, v_hi, a_hi, b_hi} = '0;

        #3;
        check("reset_hlv", {5'b0, h1, l1, ov1}, 8'b000);
        tick();
        check("reset_hold_edge", {5'b0, h1, l1, ov1}, 8'b000);
        rst_n = 1'b1;

        // First edge after release samples normally.
        {v1, a1, b1, c1} = 4'b1111;
        tick();
        check("post_reset_first", {5'b0, h1, l1, ov1}, 8'b111);

        // Asynchronous clear mid-cycle, well before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {5'b0, h1, l1, ov1}, 8'b000);
        #1;
        rst_n = 1'b1;

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            v1 = 1'b1;
            {a1, b1, c1} = abc;
            tick();
            check($sformatf("sweep_%0d_hl", i), {6'b0, h1, l1}, {6'b0, exp_tbl[i]});
            check($sformatf("sweep_%0d_ov", i), {7'b0, ov1}, 8'd1);
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
            check($sformatf("sweep_%0d_err", i), {7'b0, err1}, 8'd0);
`endif
        end

        // Hold: idle inputs must not disturb the stored result.
        {v1, a1, b1, c1} = 4'b1110;
        tick();
        check("hold_load", {5'b0, h1, l1, ov1}, 8'b101);
        {v1, a1, b1, c1} = 4'b0001;
        tick();
        check("hold_keep", {5'b0, h1, l1, ov1}, 8'b100);
        a1 = 1'bx; b1 = 1'bx; c1 = 1'bx;
        tick();
        check("hold_x_in", {5'b0, h1, l1, ov1}, 8'b100);

        // LANES=4 independent slices.
        v4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110; c4 = 4'b0011;
        tick();
        check("lanes4_h", {4'b0, h4}, 8'b0010);
        check("lanes4_l", {4'b0, l4}, 8'b1111);
        check("lanes4_ov", {7'b0, ov4}, 8'd1);
        v4 = 1'b0; a4 = 4'b0000; b4 = 4'b0000; c4 = 4'b0000;
        tick();
        check("lanes4_hold", {h4, l4}, {4'b0010, 4'b1111});
        check("lanes4_ov_drop", {7'b0, ov4}, 8'd0);

        // Ripple chain: 2'b11 + 2'b01 + 1 = 5 -> cout 1, sum 2'b01.
        v_lo = 1'b1; a_lo = 1'b1; b_lo = 1'b1; c_lo = 1'b1;
        tick();
        v_lo = 1'b0;
        v_hi = 1'b1; a_hi = 1'b1; b_hi = 1'b0;
        tick();
        v_hi = 1'b0;
        check("chain_sum", {6'b0, l_hi, l_lo}, 8'b01);
        check("chain_cout", {7'b0, h_hi}, 8'd1);

        // Reset mid-stream: the in-flight result must never surface.
        {v1, a1, b1, c1} = 4'b1111;
        #2;
        rst_n = 1'b0;
        tick();
        {v1, a1, b1, c1} = 4'b0000;
        rst_n = 1'b1;
        check("midstream_cleared", {5'b0, h1, l1, ov1}, 8'b000);
        tick();
        check("midstream_no_stale", {5'b0, h1, l1, ov1}, 8'b000);
`ifdef GATE_LEVEL_FULL_ADDER_CHECK_EN
        check("midstream_err", {7'b0, err1}, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule
